// File: rtl/lift_pkg.sv
// Shared constants and saturation helpers for the 5/3 lifting engine.
package lift_pkg;
    localparam int DW = 8;
    localparam int RW = DW + 1;

    localparam logic [2:0] FWD_PREDICT = 3'd7;
    localparam logic [2:0] FWD_UPDATE  = 3'd5;
    localparam logic [2:0] INV_PREDICT = 3'd6;
    localparam logic [2:0] INV_UPDATE  = 3'd4;

    // Clamp an RW+1-bit signed value into the RW-bit signed range.
    function automatic logic [RW-1:0] sat9(input logic signed [RW:0] v);
        if (v > $signed({2'b00, {(RW-1){1'b1}}}))
            return {1'b0, {(RW-1){1'b1}}};
        else if (v < $signed({2'b11, {(RW-1){1'b0}}}))
            return {1'b1, {(RW-1){1'b0}}};
        else
            return v[RW-1:0];
    endfunction

    // Clamp an RW-bit signed value into the DW-bit signed range.
    function automatic logic [DW-1:0] sat8(input logic signed [RW-1:0] v);
        if (v > $signed({2'b00, {(DW-1){1'b1}}}))
            return {1'b0, {(DW-1){1'b1}}};
        else if (v < $signed({2'b11, {(DW-1){1'b0}}}))
            return {1'b1, {(DW-1){1'b0}}};
        else
            return v[DW-1:0];
    endfunction
endpackage

// File: rtl/lift_res_to_byte.sv
// Registers the 9-bit lifted result as a saturated signed byte, every clock.
module lift_res_to_byte
    import lift_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [RW-1:0] res_o,
    output logic [DW-1:0] z_o
);
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) z_o <= '0;
        else          z_o <= sat8($signed(res_o));
    end
endmodule

// File: rtl/lift_step_dwt.sv
// One predict/update step of the integer 5/3 DWT on a centre sample and its neighbours.
module lift_step_dwt
    import lift_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [2:0]    flags_i,
    input  logic          update_i,
    input  logic [DW-1:0] left_i,
    input  logic [DW-1:0] sam_i,
    input  logic [DW-1:0] right_i,
    output logic [RW-1:0] res_o,
    output logic          update_o,
    output logic [DW-1:0] z_o
);
    logic [RW:0]        sum_w;
    logic signed [RW:0] sam_s, half_s, quart_s, t;
    logic               op_ok;

    // Everything is widened to RW+1 bits so sum+2 and sam+(sum>>1) never wrap.
    assign sum_w   = {2'b00, left_i} + {2'b00, right_i};
    assign sam_s   = $signed({2'b00, sam_i});
    assign half_s  = $signed(sum_w >> 1);
    assign quart_s = $signed((sum_w + (RW+1)'(2)) >> 2);

    always_comb begin
        t     = '0;
        op_ok = 1'b1;
        case (flags_i)
            FWD_PREDICT: t = sam_s - half_s;
            FWD_UPDATE:  t = sam_s + quart_s;
            INV_PREDICT: t = sam_s + half_s;
            INV_UPDATE:  t = sam_s - quart_s;
            default:     op_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            res_o    <= '0;
            update_o <= 1'b0;
        end else begin
            update_o <= update_i && op_ok;
            if (update_i && op_ok) res_o <= sat9(t);
        end
    end

    lift_res_to_byte u_byte (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .res_o   (res_o),
        .z_o     (z_o)
    );
endmodule

// File: tb/tb_lift_step_dwt.sv
// Randomized bench for lift_step_dwt against an arithmetic reference, plus directed literals.
module tb_lift_step_dwt;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] flags = 3'd0;
    logic       upd = 1'b0;
    logic [7:0] left = 8'd0, sam = 8'd0, right = 8'd0;
    logic [8:0] res_o;
    logic       update_o;
    logic [7:0] z_o;

    int checks = 0, passed = 0;
    int exp_res = 0, exp_z = 0;
    logic exp_upd = 1'b0;

    lift_step_dwt dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .flags_i  (flags),
        .update_i (upd),
        .left_i   (left),
        .sam_i    (sam),
        .right_i  (right),
        .res_o    (res_o),
        .update_o (update_o),
        .z_o      (z_o)
    );

    always #5 clk = ~clk;

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // Plain-integer lifting rules; returns 1 when the flag selects an operation.
    function automatic bit lift_ref(input int f, input int l, input int s, input int r, output int t);
        int sum;
        sum = l + r;
        t = 0;
        case (f)
            7: t = s - sum / 2;
            5: t = s + (sum + 2) / 4;
            6: t = s + sum / 2;
            4: t = s - (sum + 2) / 4;
            default: return 1'b0;
        endcase
        t = clamp(t, -256, 255);
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int t;
        bit ok;
        if (!rst_n) begin
            exp_res <= 0;
            exp_upd <= 1'b0;
            exp_z   <= 0;
        end else begin
            ok = lift_ref(int'(flags), int'(left), int'(sam), int'(right), t);
            exp_z   <= clamp(exp_res, -128, 127);
            exp_upd <= ok && upd;
            if (ok && upd) exp_res <= t;
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got == want) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_res", int'($signed(res_o)), exp_res);
            chk("model_upd", int'(update_o), int'(exp_upd));
            chk("model_z", int'(z_o), exp_z & 255);
        end
    end

    task automatic drive(input int f, input int l, input int s, input int r, input bit u);
        flags = 3'(f); left = 8'(l); sam = 8'(s); right = 8'(r); upd = u;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_res", int'(res_o), 0);
        chk("rst_upd", int'(update_o), 0);
        chk("rst_z", int'(z_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick();
        chk("idle_res", int'(res_o), 0);
        chk("idle_upd", int'(update_o), 0);

        drive(7, 68, 218, 163, 1'b1); tick();
        upd = 1'b0;
        chk("fp_res", int'($signed(res_o)), 103);
        chk("fp_upd", int'(update_o), 1);
        tick();
        chk("fp_upd_drop", int'(update_o), 0);
        chk("fp_z", int'(z_o), 103);

        drive(5, 68, 231, 163, 1'b1); tick();
        upd = 1'b0;
        chk("fu_sat_res", int'($signed(res_o)), 255);
        tick();
        chk("fu_sat_z", int'(z_o), 127);

        drive(6, 164, 250, 160, 1'b1); tick();
        chk("ip_sat_res", int'($signed(res_o)), 255);
        drive(4, 164, 203, 160, 1'b1); tick();
        upd = 1'b0;
        chk("iu_res", int'($signed(res_o)), 122);
        tick();
        chk("iu_z", int'(z_o), 122);

        drive(7, 255, 0, 255, 1'b1); tick();
        upd = 1'b0;
        chk("neg_res_raw", int'(res_o), 'h101);
        tick();
        chk("neg_z", int'(z_o), 'h80);

        drive(2, 1, 2, 3, 1'b1); tick();
        chk("bad_flag_hold", int'(res_o), 'h101);
        chk("bad_flag_upd", int'(update_o), 0);
        upd = 1'b0;

        drive(7, 10, 100, 20, 1'b1); tick();
        chk("burst0_res", int'($signed(res_o)), 85);
        chk("burst0_upd", int'(update_o), 1);
        drive(7, 10, 50, 20, 1'b1); tick();
        chk("burst1_res", int'($signed(res_o)), 35);
        drive(7, 10, 0, 20, 1'b1); tick();
        chk("burst2_res", int'($signed(res_o)), -15);
        chk("burst2_upd", int'(update_o), 1);
        upd = 1'b0;
        tick();
        chk("burst_end_upd", int'(update_o), 0);

        for (int i = 0; i < 400; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            drive(int'($urandom_range(0, 7)),
                  (sel == 0) ? 0 : ((sel == 1) ? 255 : int'($urandom_range(0, 255))),
                  (sel == 2) ? 0 : ((sel == 3) ? 255 : int'($urandom_range(0, 255))),
                  (sel == 1) ? 255 : int'($urandom_range(0, 255)),
                  $urandom_range(0, 3) != 0);
            if (i == 200) begin
                #2 rst_n = 1'b0;
                #1;
                chk("mid_rst_res", int'(res_o), 0);
                chk("mid_rst_upd", int'(update_o), 0);
                chk("mid_rst_z", int'(z_o), 0);
                upd = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            tick();
        end
        upd = 1'b0;
        tick(); tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
